led_ctrl: RTL and testbench

Parametrised LED output stage for the Atlys Spartan-6 board top, sitting between the processor's output-register writes and the physical `Led` pins. It latches the value the processor writes and displays it in one of four modes: direct, blink, scroll (rotate) or PWM-dimmed. Blink and scroll are paced by an internal prescaled tick, so display behaviour is independent of processor timing.

---
 rtl/led_ctrl_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 41 ++++
 rtl/led_ctrl.sv | 107 ++++++++++
 tb/tb_led_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED output stage.
// Mode encoding matches the processor's cfg_mode field.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_PWM    = 2'd3
  } led_mode_t;

  // Clock cycles per blink/scroll tick; caller must keep the result >= 2.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter producing a registered one-cycle tick.
// A clr restarts the count so the next tick lands DIV cycles later.
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] presc_q, presc_d;
  logic         tick_q, tick_d;

  always_comb begin
    presc_d = presc_q + W'(1);
    tick_d  = 1'b0;
    if (clr) begin
      presc_d = '0;
    end else if (presc_q == LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_ctrl.sv
// LED output stage: latches processor writes and shows them direct, blinking,
// scrolling or PWM-dimmed. Led is driven straight from a flop.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 4,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [NUM_LEDS-1:0] wr_data,
  input  logic                cfg_en,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [NUM_LEDS-1:0] Led,
  output logic                tick
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

  logic [NUM_LEDS-1:0] data_q, data_d;
  logic [NUM_LEDS-1:0] shift_q, shift_d, shift_rot;
  led_mode_t           mode_q, mode_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  tick_prescaler #(
    .DIV (DIV)
  ) u_tick_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (cfg_en),
    .tick (tick)
  );

  if (NUM_LEDS == 1) begin : g_rot_single
    assign shift_rot = shift_q;
  end else begin : g_rot_multi
    assign shift_rot = {shift_q[NUM_LEDS-2:0], shift_q[NUM_LEDS-1]};
  end

  // Later assignments take priority: write beats config beats tick.
  always_comb begin
    data_d    = data_q;
    shift_d   = shift_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    phase_d   = phase_q;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

    if (tick) begin
      phase_d = ~phase_q;
      if (mode_q == MODE_SCROLL) begin
        shift_d = shift_rot;
      end
    end
    if (cfg_en) begin
      mode_d  = led_mode_t'(cfg_mode);
      duty_d  = cfg_duty;
      phase_d = 1'b1;
      shift_d = data_q;
    end
    if (wr_en) begin
      data_d  = wr_data;
      shift_d = wr_data;
    end
  end

  always_comb begin
    led_d = '0;
    unique case (mode_q)
      MODE_DIRECT: led_d = data_q;
      MODE_BLINK:  led_d = phase_q ? data_q : '0;
      MODE_SCROLL: led_d = shift_q;
      MODE_PWM:    led_d = ((duty_q == '1) || (pwm_cnt_q < duty_q)) ? data_q : '0;
      default:     led_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      shift_q   <= '0;
      mode_q    <= MODE_DIRECT;
      duty_q    <= '1;
      phase_q   <= 1'b1;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      data_q    <= data_d;
      shift_q   <= shift_d;
      mode_q    <= mode_d;
      duty_q    <= duty_d;
      phase_q   <= phase_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign Led = led_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Randomised and directed bench for led_ctrl, checked every cycle against a
// time-based reference model (ticks and phase derived from cycles since config).
module tb_led_ctrl;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_req = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       cfg_en = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_duty = '0;
  logic [7:0] Led;
  logic       tick;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // Reference model state
  logic [7:0] m_data, m_shift, m_led;
  logic [1:0] m_mode;
  logic [3:0] m_duty;
  logic       m_tick;
  int         m_t;   // edges since last cfg_en (or reset)
  int         m_n;   // edges since reset

  led_ctrl #(
    .NUM_LEDS (8),
    .CLK_HZ   (100),
    .TICK_HZ  (10),
    .PWM_BITS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .cfg_en   (cfg_en),
    .cfg_mode (cfg_mode),
    .cfg_duty (cfg_duty),
    .Led      (Led),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  function automatic bit phase_at(input int t);
    if (t == 0) return 1'b1;
    return (((t - 1) / DIV) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_data = '0; m_shift = '0; m_led = '0; m_mode = 2'd0; m_duty = 4'hF;
    m_tick = 1'b0; m_t = 0; m_n = 0;
  endtask

  task automatic model_edge();
    logic [7:0] nled;
    case (m_mode)
      2'd0:    nled = m_data;
      2'd1:    nled = phase_at(m_t) ? m_data : 8'h00;
      2'd2:    nled = m_shift;
      default: nled = (m_duty == 4'hF || (m_n % 16) < int'(m_duty)) ? m_data : 8'h00;
    endcase
    if (cfg_en) begin
      m_t = 0;
      m_shift = m_data;
    end else begin
      m_t++;
      if (m_mode == 2'd2 && m_tick) m_shift = 8'(((m_shift << 1) | (m_shift >> 7)) & 8'hFF);
    end
    if (cfg_en) begin
      m_mode = cfg_mode;
      m_duty = cfg_duty;
    end
    if (wr_en) begin
      m_data = wr_data;
      m_shift = wr_data;
    end
    m_n++;
    m_led  = nled;
    m_tick = (m_t > 0) && (m_t % DIV == 0);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (Led !== m_led || tick !== m_tick) begin
        miscompares++;
        $display("FAIL model t=%0t Led=%h tick=%b expected Led=%h tick=%b",
                 $time, Led, tick, m_led, m_tick);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] wd, input logic c,
                     input logic [1:0] cm, input logic [3:0] cd);
    @(negedge clk);
    rst = rst_req; wr_en = w; wr_data = wd; cfg_en = c; cfg_mode = cm; cfg_duty = cd;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 2'd0, 4'h0);
  endtask

  // Must be called just after an edge (#1); leaves tick high for the next edge.
  task automatic wait_tick(input string name);
    int k = 0;
    while (!tick && k < 30) begin
      idle(1); #1; k++;
    end
    chk(name, int'(tick), 1);
  endtask

  task automatic count_on(input int n, input logic [7:0] pat, output int on);
    on = 0;
    repeat (n) begin
      idle(1); #1;
      if (Led == pat) on++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int first, on, bad;
    model_reset();
    chk_on = 1'b1;

    // Reset and first tick
    idle(3);
    rst_req = 1'b0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      idle(1); #1;
      if (i == 1) begin
        chk("reset_led", int'(Led), 'h00);
        chk("reset_tick", int'(tick), 0);
      end
      if (tick && first == 0) first = i;
    end
    chk("first_tick_cycle", first, 10);

    // DIRECT
    cyc(1'b1, 8'hA5, 1'b0, 2'd0, 4'h0);
    idle(1); #1;
    chk("direct_led", int'(Led), 'hA5);
    count_on(100, 8'hA5, on);
    chk("direct_stable", on, 100);

    // BLINK
    cyc(1'b1, 8'h3C, 1'b0, 2'd0, 4'h0);
    cyc(1'b0, 8'h00, 1'b1, 2'd1, 4'hF);
    bad = 0; on = 0;
    for (int j = 1; j <= 81; j++) begin
      idle(1); #1;
      if (j >= 2) begin
        if ((Led == 8'h3C) != (((j - 2) / 10) % 2 == 0)) bad++;
        if (Led == 8'h3C) on++;
      end
    end
    chk("blink_pattern_errs", bad, 0);
    chk("blink_on_cycles", on, 40);

    // SCROLL
    cyc(1'b1, 8'h81, 1'b0, 2'd0, 4'h0);
    cyc(1'b0, 8'h00, 1'b1, 2'd2, 4'hF);
    for (int j = 1; j <= 35; j++) begin
      idle(1); #1;
      if (j == 5)  chk("scroll_step0", int'(Led), 'h81);
      if (j == 15) chk("scroll_step1", int'(Led), 'h03);
      if (j == 25) chk("scroll_step2", int'(Led), 'h06);
      if (j == 35) chk("scroll_step3", int'(Led), 'h0C);
    end
    wait_tick("scroll_tick_wait");
    cyc(1'b1, 8'h01, 1'b0, 2'd0, 4'h0);
    idle(1); #1;
    chk("scroll_wr_on_tick", int'(Led), 'h01);
    idle(5); #1;
    chk("scroll_wr_no_rotate", int'(Led), 'h01);

    // Config landing on a tick cycle
    wait_tick("cfg_tick_wait");
    cyc(1'b0, 8'h00, 1'b1, 2'd1, 4'hF);
    idle(12);

    // PWM
    cyc(1'b1, 8'hFF, 1'b0, 2'd0, 4'h0);
    cyc(1'b0, 8'h00, 1'b1, 2'd3, 4'd4);
    idle(2);
    count_on(16, 8'hFF, on);
    chk("pwm_duty4_on", on, 4);
    cyc(1'b0, 8'h00, 1'b1, 2'd3, 4'd0);
    idle(2);
    count_on(32, 8'hFF, on);
    chk("pwm_duty0_on", on, 0);
    cyc(1'b0, 8'h00, 1'b1, 2'd3, 4'd15);
    idle(2);
    count_on(32, 8'hFF, on);
    chk("pwm_duty15_on", on, 32);

    // Async reset mid-scroll
    cyc(1'b1, 8'h5A, 1'b0, 2'd0, 4'h0);
    cyc(1'b0, 8'h00, 1'b1, 2'd2, 4'hF);
    idle(15);
    #2;
    rst = 1'b1; rst_req = 1'b1;
    model_reset();
    #1;
    chk("async_rst_led", int'(Led), 'h00);
    chk("async_rst_tick", int'(tick), 0);
    idle(2);
    rst_req = 1'b0;
    idle(1);
    cyc(1'b1, 8'h77, 1'b0, 2'd0, 4'h0);
    idle(1); #1;
    chk("post_rst_direct", int'(Led), 'h77);
    idle(25); #1;
    chk("post_rst_direct_hold", int'(Led), 'h77);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic       w, c;
      logic [7:0] d;
      logic [1:0] m;
      logic [3:0] u;
      w = ($urandom % 8) == 0;
      c = ($urandom % 16) == 0;
      d = 8'($urandom);
      m = 2'($urandom);
      u = 4'($urandom);
      cyc(w, d, c, m, u);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
